sram_wb_writer: RTL and testbench

Wishbone B3 classic single-write master directly downstream of the FIFO-to-SRAM unloader. Captures one 32-bit word per sram_start pulse and writes it to a circular sample buffer in SRAM. Returns a one-cycle data_done pulse on completion, which lets the unloader send the next word. Tracks the write index, wrap-around and bus errors for the DSP control registers.

---
 rtl/sram_wb_writer.sv | 181 ++++++++++++++++++
 tb/tb_sram_wb_writer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_wb_writer.sv
// Wishbone B3 classic single-write master that stores one word per request into a circular SRAM buffer.
// Optional ack timeout is compiled in with `define SRAM_WB_TIMEOUT_EN.
module sram_wb_writer #(
  parameter int unsigned             ADDR_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR      = '0,
  parameter int unsigned             NUM_WORDS      = 16,
  parameter int unsigned             TIMEOUT_CYCLES = 255
) (
  input  logic                          wb_clk,
  input  logic                          wb_rst_n,
  input  logic                          sram_start,
  input  logic [31:0]                   sram_data_in,
  input  logic                          clear,
  output logic                          data_done,
  output logic [ADDR_WIDTH-1:0]         wb_adr_o,
  output logic [31:0]                   wb_dat_o,
  output logic [3:0]                    wb_sel_o,
  output logic                          wb_we_o,
  output logic                          wb_cyc_o,
  output logic                          wb_stb_o,
  input  logic                          wb_ack_i,
  input  logic                          wb_err_i,
  output logic [$clog2(NUM_WORDS)-1:0]  write_index,
  output logic                          wrapped,
  output logic                          error,
  output logic                          overrun
);

  localparam int unsigned IDX_W = $clog2(NUM_WORDS);

  if (NUM_WORDS < 2) begin : g_bad_num_words
    $error("NUM_WORDS must be at least 2");
  end
  if (BASE_ADDR[1:0] != 2'b00) begin : g_bad_base_addr
    $error("BASE_ADDR must be 4-byte aligned");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_next;

  logic start_write;
  logic term;
  logic term_err;
  logic timeout;
  logic clear_pend;
  logic kill;
  logic idx_last;

  function automatic logic [ADDR_WIDTH-1:0] slot_addr(input logic [IDX_W-1:0] idx);
    return BASE_ADDR + (ADDR_WIDTH'(idx) << 2);
  endfunction

  assign start_write = (state == IDLE) && sram_start;
  assign term        = (state == WRITE) && (wb_ack_i || wb_err_i || timeout);
  // err wins over a simultaneous ack
  assign term_err    = wb_err_i || timeout;
  assign kill        = clear || clear_pend;
  assign idx_last    = (write_index == IDX_W'(NUM_WORDS - 1));

`ifdef SRAM_WB_TIMEOUT_EN
  localparam int unsigned TO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      to_cnt <= '0;
    end else if (start_write) begin
      to_cnt <= '0;
    end else if (state == WRITE) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  // Counter is 0 in the first WRITE cycle, so the bus is held for exactly TIMEOUT_CYCLES cycles
  assign timeout = (state == WRITE) && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (sram_start) state_next = WRITE;
      WRITE:   if (term)       state_next = DONE;
      DONE:                    state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  // Bus outputs: launch on request, hold through WRITE, release on termination
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      wb_adr_o  <= '0;
      wb_dat_o  <= '0;
      wb_sel_o  <= 4'h0;
      wb_we_o   <= 1'b0;
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
      data_done <= 1'b0;
    end else begin
      data_done <= (state == DONE);
      if (start_write) begin
        wb_dat_o <= sram_data_in;
        wb_adr_o <= slot_addr(clear ? '0 : write_index);
        wb_sel_o <= 4'hF;
        wb_we_o  <= 1'b1;
        wb_cyc_o <= 1'b1;
        wb_stb_o <= 1'b1;
      end else if (term) begin
        wb_sel_o <= 4'h0;
        wb_we_o  <= 1'b0;
        wb_cyc_o <= 1'b0;
        wb_stb_o <= 1'b0;
      end
    end
  end

  // A clear seen during WRITE must leave the index at 0 even if the ack arrives later
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      clear_pend <= 1'b0;
    end else if (term) begin
      clear_pend <= 1'b0;
    end else if ((state == WRITE) && clear) begin
      clear_pend <= 1'b1;
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      write_index <= '0;
      wrapped     <= 1'b0;
      error       <= 1'b0;
    end else if (term) begin
      if (kill) begin
        write_index <= '0;
        wrapped     <= 1'b0;
        error       <= 1'b0;
      end else if (term_err) begin
        error <= 1'b1;
      end else if (idx_last) begin
        write_index <= '0;
        wrapped     <= 1'b1;
      end else begin
        write_index <= write_index + IDX_W'(1);
      end
    end else if (clear) begin
      write_index <= '0;
      wrapped     <= 1'b0;
      error       <= 1'b0;
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      overrun <= 1'b0;
    end else if (clear) begin
      overrun <= 1'b0;
    end else if (sram_start && (state != IDLE)) begin
      overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_wb_writer.sv
// Directed self-checking bench for sram_wb_writer: address sequencing, wrap, errors, overrun, clear, stall/timeout.
// Build with +define+SRAM_WB_TIMEOUT_EN to exercise the ack timeout instead of the indefinite stall.
module tb_sram_wb_writer;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int          NW   = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sram_start = 1'b0;
  logic [31:0] sram_data_in = '0;
  logic        clear = 1'b0;
  logic        data_done;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_ack_i = 1'b0;
  logic        wb_err_i = 1'b0;
  logic [3:0]  write_index;
  logic        wrapped;
  logic        error;
  logic        overrun;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sram_wb_writer #(
    .ADDR_WIDTH     (32),
    .BASE_ADDR      (BASE),
    .NUM_WORDS      (NW),
    .TIMEOUT_CYCLES (10)
  ) dut (
    .wb_clk       (clk),
    .wb_rst_n     (rst_n),
    .sram_start   (sram_start),
    .sram_data_in (sram_data_in),
    .clear        (clear),
    .data_done    (data_done),
    .wb_adr_o     (wb_adr_o),
    .wb_dat_o     (wb_dat_o),
    .wb_sel_o     (wb_sel_o),
    .wb_we_o      (wb_we_o),
    .wb_cyc_o     (wb_cyc_o),
    .wb_stb_o     (wb_stb_o),
    .wb_ack_i     (wb_ack_i),
    .wb_err_i     (wb_err_i),
    .write_index  (write_index),
    .wrapped      (wrapped),
    .error        (error),
    .overrun      (overrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // One complete transaction; caller is #1 after a posedge with the DUT idle
  task automatic write_word(input logic [31:0] d, input int ws, input bit use_err,
                            input bit with_clear, input logic [31:0] exp_adr);
    sram_start   = 1'b1;
    sram_data_in = d;
    clear        = with_clear;
    tick();
    sram_start   = 1'b0;
    clear        = 1'b0;
    sram_data_in = 32'h0BAD_0BAD;
    check("cyc_launch", {31'd0, wb_cyc_o}, 32'd1);
    check("stb_we", {30'd0, wb_stb_o, wb_we_o}, 32'd3);
    check("sel", {28'd0, wb_sel_o}, 32'hF);
    check("adr", wb_adr_o, exp_adr);
    check("dat", wb_dat_o, d);
    for (int i = 0; i < ws; i++) begin
      tick();
      check("cyc_hold", {31'd0, wb_cyc_o}, 32'd1);
      check("adr_hold", wb_adr_o, exp_adr);
    end
    if (use_err) wb_err_i = 1'b1;
    else         wb_ack_i = 1'b1;
    tick();
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    check("cyc_release", {29'd0, wb_cyc_o, wb_stb_o, wb_we_o}, 32'd0);
    check("sel_release", {28'd0, wb_sel_o}, 32'd0);
    check("done_early", {31'd0, data_done}, 32'd0);
    tick();
    check("done_pulse", {31'd0, data_done}, 32'd1);
    tick();
    check("done_end", {31'd0, data_done}, 32'd0);
  endtask

  initial begin
    int hi;
    int cnt_cyc;
    int cnt_done;
    logic prev_cyc;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {data_done, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, write_index,
                          wrapped, error, overrun}, 32'd0);
    check("rst_adr", wb_adr_o, 32'd0);
    check("rst_dat", wb_dat_o, 32'd0);
    rst_n = 1'b1;
    tick();

    // Single write, zero wait states
    write_word(32'hDEAD_BEEF, 0, 1'b0, 1'b0, BASE);
    check("t1_index", {28'd0, write_index}, 32'd1);

    // Full buffer pass with two wait states per write
    do_clear();
    check("t2_index_cleared", {28'd0, write_index}, 32'd0);
    for (int i = 0; i < NW; i++) begin
      write_word(32'hA500_0000 + i, 2, 1'b0, 1'b0, BASE + 32'(4 * i));
      if (i == NW - 2) check("t2_not_wrapped", {31'd0, wrapped}, 32'd0);
    end
    check("t2_index_wrap", {28'd0, write_index}, 32'd0);
    check("t2_wrapped", {31'd0, wrapped}, 32'd1);

    // Bus error on the fourth write; slot is reused
    do_clear();
    check("t3_wrapped_cleared", {31'd0, wrapped}, 32'd0);
    for (int i = 0; i < 3; i++) write_word(32'h1111_0000 + i, 0, 1'b0, 1'b0, BASE + 32'(4 * i));
    write_word(32'h3333_3333, 1, 1'b1, 1'b0, BASE + 32'h0C);
    check("t3_error", {31'd0, error}, 32'd1);
    check("t3_index_held", {28'd0, write_index}, 32'd3);
    write_word(32'h4444_4444, 0, 1'b0, 1'b0, BASE + 32'h0C);
    check("t3_index_next", {28'd0, write_index}, 32'd4);
    check("t3_error_sticky", {31'd0, error}, 32'd1);

    // Start while busy: overrun, one bus cycle, one done pulse
    do_clear();
    check("t4_error_cleared", {31'd0, error}, 32'd0);
    sram_start   = 1'b1;
    sram_data_in = 32'h5555_AAAA;
    tick();
    sram_data_in = 32'h6666_BBBB;
    check("t4_cyc", {31'd0, wb_cyc_o}, 32'd1);
    tick();
    sram_start = 1'b0;
    check("t4_overrun", {31'd0, overrun}, 32'd1);
    check("t4_dat_stable", wb_dat_o, 32'h5555_AAAA);
    wb_ack_i = 1'b1;
    tick();
    wb_ack_i = 1'b0;
    cnt_cyc  = 0;
    cnt_done = 0;
    prev_cyc = wb_cyc_o;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (wb_cyc_o && !prev_cyc) cnt_cyc++;
      if (data_done) cnt_done++;
      prev_cyc = wb_cyc_o;
    end
    check("t4_extra_cycles", 32'(cnt_cyc), 32'd0);
    check("t4_done_count", 32'(cnt_done), 32'd1);
    check("t4_index", {28'd0, write_index}, 32'd1);

    // Clear while waiting for ack at slot 5
    do_clear();
    for (int i = 0; i < 5; i++) write_word(32'h7700_0000 + i, 0, 1'b0, 1'b0, BASE + 32'(4 * i));
    write_word(32'h7777_0005, 0, 1'b1, 1'b0, BASE + 32'h14);
    check("t5_error_set", {31'd0, error}, 32'd1);
    sram_start   = 1'b1;
    sram_data_in = 32'h8888_0005;
    tick();
    sram_start = 1'b0;
    check("t5_adr", wb_adr_o, BASE + 32'h14);
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("t5_cyc_still", {31'd0, wb_cyc_o}, 32'd1);
    check("t5_adr_still", wb_adr_o, BASE + 32'h14);
    tick();
    wb_ack_i = 1'b1;
    tick();
    wb_ack_i = 1'b0;
    check("t5_cyc_drop", {31'd0, wb_cyc_o}, 32'd0);
    tick();
    check("t5_done", {31'd0, data_done}, 32'd1);
    check("t5_state_regs", {28'd0, write_index, wrapped, error, overrun}, 32'd0);
    tick();

    // Clear together with start: targets slot 0, index becomes 1
    write_word(32'h9999_0000, 0, 1'b0, 1'b0, BASE);
    write_word(32'h9999_0001, 0, 1'b0, 1'b0, BASE + 32'h4);
    write_word(32'h9999_0002, 1, 1'b0, 1'b1, BASE);
    check("t7_index", {28'd0, write_index}, 32'd1);

    // Slave never responds
    sram_start   = 1'b1;
    sram_data_in = 32'hCAFE_F00D;
    tick();
    sram_start = 1'b0;
    hi = 0;
    if (wb_cyc_o) hi = 1;
`ifdef SRAM_WB_TIMEOUT_EN
    for (int i = 0; i < 50; i++) begin
      tick();
      if (!wb_cyc_o) break;
      hi++;
    end
    check("t6_timeout_len", 32'(hi), 32'd10);
    check("t6_timeout_err", {31'd0, error}, 32'd1);
    check("t6_timeout_idx", {28'd0, write_index}, 32'd1);
    tick();
    check("t6_timeout_done", {31'd0, data_done}, 32'd1);
    tick();
    sram_start   = 1'b1;
    sram_data_in = 32'hCAFE_F00E;
    tick();
    sram_start = 1'b0;
`else
    for (int i = 0; i < 99; i++) begin
      tick();
      if (wb_cyc_o) hi++;
    end
    check("t6_stall_len", 32'(hi), 32'd100);
    check("t6_stall_no_err", {31'd0, error}, 32'd0);
`endif

    // Reset in the middle of a bus cycle
    check("t8_pre_cyc", {31'd0, wb_cyc_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t8_async_drop", {29'd0, wb_cyc_o, wb_stb_o, wb_we_o}, 32'd0);
    cnt_done = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (data_done) cnt_done++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (data_done || wb_cyc_o) cnt_done++;
    end
    check("t8_no_done", 32'(cnt_done), 32'd0);
    check("t8_index_reset", {28'd0, write_index}, 32'd0);
    write_word(32'h0123_4567, 0, 1'b0, 1'b0, BASE);
    check("t8_index_after", {28'd0, write_index}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
